// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier accumulate path.
package booth_pkg;

    localparam int unsigned PROD_W    = 16;
    localparam int unsigned ACC_W_DEF = 24;
    localparam int unsigned CNT_W_DEF = 8;
    // Working width of sat_add; accumulators must be narrower than this.
    localparam int unsigned SAT_W     = 64;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    typedef struct packed {
        logic signed [SAT_W-1:0] sum;
        logic                    ovf;
    } sat_res_t;

    // acc (already sign-extended from acc_w bits) + sext(prod).
    // ovf is set when the true sum leaves the acc_w-bit signed range, which is
    // the same as the top two bits of an (acc_w+1)-bit sum differing.
    // With sat set the result is clamped toward the sign of prod; otherwise
    // the caller keeps the low acc_w bits, which wraps.
    function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0]  acc,
                                         input logic signed [PROD_W-1:0] prod,
                                         input int unsigned              acc_w,
                                         input logic                     sat);
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] vmax;
        logic signed [SAT_W-1:0] vmin;
        sat_res_t                res;
        sum     = acc + {{(SAT_W-PROD_W){prod[PROD_W-1]}}, prod};
        vmax    = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        vmin    = -vmax - 64'sd1;
        res.ovf = (sum > vmax) || (sum < vmin);
        if (sat && res.ovf) begin
            res.sum = prod[PROD_W-1] ? vmin : vmax;
        end else begin
            res.sum = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/booth_sat_adder.sv
// Combinational accumulator adder: acc + sext(prod) with overflow detect and
// optional saturation.
module booth_sat_adder
    import booth_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned SAT   = 1
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [SAT_W-1:0] w_acc_ext;
    sat_res_t         w_res;
    logic             w_unused;

    assign w_acc_ext = {{(SAT_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};

    // Evaluate the shared saturating add at the working width.
    always_comb begin
        w_res = sat_add(w_acc_ext, prod_i, ACC_W, SAT != 0);
    end

    // Upper bits are redundant after clamp; dropping them gives wrap mode.
    assign sum_o    = w_res.sum[ACC_W-1:0];
    assign ovf_o    = w_res.ovf;
    assign w_unused = ^w_res.sum[SAT_W-1:ACC_W];

endmodule

// File: rtl/booth_mac_acc.sv
// Frame accumulator behind the Booth multiplier: sums a stream of signed
// products per frame and hands the result out over valid/ready.
module booth_mac_acc
    import booth_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned SAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic [ACC_W-1:0]  acc_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              ovf_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    state_e           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    state_e           w_state_d;
    logic [ACC_W-1:0] w_acc_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_ovf_d;
    logic [ACC_W-1:0] w_sum;
    logic             w_add_ovf;
    logic             w_beat;

    booth_sat_adder #(
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_adder (
        .acc_i  (r_acc),
        .prod_i (prod_i),
        .sum_o  (w_sum),
        .ovf_o  (w_add_ovf)
    );

    // Ready is gated by rst_n so it is low throughout reset and high as soon
    // as reset releases, without waiting for a clock edge.
    assign in_ready_o  = rst_n && (r_state == ACCUM);
    assign out_valid_o = (r_state == DONE);
    assign acc_o       = r_acc;
    assign cnt_o       = r_cnt;
    assign ovf_o       = r_ovf;
    assign w_beat      = in_valid_i && in_ready_o;

    // Next-state: clear dominates, then accumulate or result hand-off.
    always_comb begin
        w_state_d = r_state;
        w_acc_d   = r_acc;
        w_cnt_d   = r_cnt;
        w_ovf_d   = r_ovf;
        if (clr_i) begin
            w_state_d = ACCUM;
            w_acc_d   = '0;
            w_cnt_d   = '0;
            w_ovf_d   = 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_beat) begin
                        w_acc_d = w_sum;
                        w_cnt_d = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                        w_ovf_d = r_ovf | w_add_ovf;
                        if (in_last_i) begin
                            w_state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        w_state_d = ACCUM;
                        w_acc_d   = '0;
                        w_cnt_d   = '0;
                        w_ovf_d   = 1'b0;
                    end
                end
                default: w_state_d = ACCUM;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_acc   <= w_acc_d;
            r_cnt   <= w_cnt_d;
            r_ovf   <= w_ovf_d;
        end
    end

endmodule

// File: tb/tb_booth_mac_acc.sv
// Self-checking bench for booth_mac_acc: three instances (24-bit saturating,
// 16-bit saturating, 16-bit wrapping) share one stimulus stream and are
// compared against an arithmetic frame model.
module tb_booth_mac_acc;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               clr;
    logic signed [15:0] prod;
    logic               in_valid;
    logic               in_last;
    logic               out_ready;

    logic               rdy [3];
    logic               vld [3];
    logic               ovf [3];
    logic        [7:0]  cnt [3];
    logic signed [23:0] acc0;
    logic signed [15:0] acc1;
    logic signed [15:0] acc2;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int     w_of [3] = '{24, 16, 16};
    bit     s_of [3] = '{1'b1, 1'b1, 1'b0};
    longint m_acc [3];
    bit     m_ovf [3];
    int     m_cnt;
    bit     m_done;

    always #5 clk = ~clk;

    booth_mac_acc #(.ACC_W(24), .CNT_W(8), .SAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .prod_i(prod), .in_valid_i(in_valid),
        .in_last_i(in_last), .in_ready_o(rdy[0]), .acc_o(acc0), .cnt_o(cnt[0]),
        .ovf_o(ovf[0]), .out_valid_o(vld[0]), .out_ready_i(out_ready)
    );
    booth_mac_acc #(.ACC_W(16), .CNT_W(8), .SAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .prod_i(prod), .in_valid_i(in_valid),
        .in_last_i(in_last), .in_ready_o(rdy[1]), .acc_o(acc1), .cnt_o(cnt[1]),
        .ovf_o(ovf[1]), .out_valid_o(vld[1]), .out_ready_i(out_ready)
    );
    booth_mac_acc #(.ACC_W(16), .CNT_W(8), .SAT(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .prod_i(prod), .in_valid_i(in_valid),
        .in_last_i(in_last), .in_ready_o(rdy[2]), .acc_o(acc2), .cnt_o(cnt[2]),
        .ovf_o(ovf[2]), .out_valid_o(vld[2]), .out_ready_i(out_ready)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0;
            m_ovf[k] = 1'b0;
        end
        m_cnt  = 0;
        m_done = 1'b0;
    endtask

    // True-range add; clamp or wrap into w bits.
    task automatic model_add(input int k);
        longint s, hi, lo, m;
        hi = (64'sd1 <<< (w_of[k] - 1)) - 1;
        lo = -hi - 1;
        m  = 64'sd1 <<< w_of[k];
        s  = m_acc[k] + longint'(prod);
        if (s > hi || s < lo) begin
            m_ovf[k] = 1'b1;
            if (s_of[k]) begin
                s = (prod < 0) ? lo : hi;
            end else begin
                s = (s - lo) % m;
                if (s < 0) s += m;
                s += lo;
            end
        end
        m_acc[k] = s;
    endtask

    // Apply one clock edge to the model using the currently driven inputs.
    task automatic model_edge();
        if (clr) begin
            model_clear();
        end else if (!m_done) begin
            if (in_valid) begin
                for (int k = 0; k < 3; k++) model_add(k);
                if (m_cnt < 255) m_cnt++;
                if (in_last) m_done = 1'b1;
            end
        end else if (out_ready) begin
            model_clear();
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_rdy%0d", tag, k), rdy[k], !m_done);
            chk($sformatf("%s_vld%0d", tag, k), vld[k], m_done);
            chk($sformatf("%s_cnt%0d", tag, k), cnt[k], m_cnt);
            chk($sformatf("%s_ovf%0d", tag, k), ovf[k], m_ovf[k]);
        end
        chk({tag, "_acc0"}, acc0, m_acc[0]);
        chk({tag, "_acc1"}, acc1, m_acc[1]);
        chk({tag, "_acc2"}, acc2, m_acc[2]);
    endtask

    task automatic step(input string tag, input logic v, input logic l,
                        input logic signed [15:0] p, input logic r, input logic c);
        in_valid  = v;
        in_last   = l;
        prod      = p;
        out_ready = r;
        clr       = c;
        @(posedge clk);
        model_edge();
        #2;
        check_all(tag);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_rst_rdy%0d", tag, k), rdy[k], 0);
            chk($sformatf("%s_rst_vld%0d", tag, k), vld[k], 0);
            chk($sformatf("%s_rst_cnt%0d", tag, k), cnt[k], 0);
            chk($sformatf("%s_rst_ovf%0d", tag, k), ovf[k], 0);
        end
        chk({tag, "_rst_acc0"}, acc0, 0);
        chk({tag, "_rst_acc1"}, acc1, 0);
        model_clear();
        #2 rst_n = 1'b1;
        #1;
        chk({tag, "_rel_rdy"}, rdy[0], 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        prod      = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_clear();
        #3;
        chk("reset_rdy", rdy[0], 0);
        chk("reset_vld", vld[0], 0);
        chk("reset_acc", acc0, 0);
        chk("reset_cnt", cnt[0], 0);
        #9 rst_n = 1'b1;
        #1 chk("release_rdy", rdy[0], 1);

        // Three-beat frame
        step("t1", 1, 0, 16'sd16129, 1, 0);
        step("t1", 1, 0, -16'sd16256, 1, 0);
        step("t1", 1, 1, 16'sd100, 1, 0);
        chk("t1_acc_abs", acc0, -27);
        chk("t1_cnt_abs", cnt[0], 3);
        chk("t1_vld_abs", vld[0], 1);
        step("t1", 0, 0, 16'sd0, 1, 0);
        chk("t1_rdy_after", rdy[0], 1);

        // Overflow: saturate vs wrap at 16 bits
        step("t2", 1, 0, 16'sd16384, 1, 0);
        step("t2", 1, 1, 16'sd16384, 0, 0);
        chk("t2_sat_acc", acc1, 16'sh7FFF);
        chk("t2_sat_ovf", ovf[1], 1);
        chk("t2_wrap_acc", acc2, -32768);
        chk("t2_wrap_ovf", ovf[2], 1);
        chk("t2_wide_acc", acc0, 32768);
        chk("t2_wide_ovf", ovf[0], 0);
        step("t2", 0, 0, 16'sd0, 1, 0);

        // Backpressure with input still offered
        step("t3", 1, 0, 16'sd200, 0, 0);
        step("t3", 1, 1, 16'sd300, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step("t3_hold", 1, 0, 16'sd999, 0, 0);
            chk("t3_hold_acc", acc0, 500);
            chk("t3_hold_rdy", rdy[0], 0);
        end
        step("t3", 1, 0, 16'sd999, 1, 0);
        step("t3", 1, 1, 16'sd5, 1, 0);
        chk("t3_new_acc", acc0, 5);

        // Back-to-back single-beat frames
        step("t4", 0, 0, 16'sd0, 1, 0);
        step("t4", 1, 1, -16'sd16384, 1, 0);
        chk("t4_a_acc", acc0, -16384);
        chk("t4_a_cnt", cnt[0], 1);
        step("t4", 1, 1, 16'sd7, 1, 0);
        step("t4", 1, 1, 16'sd7, 1, 0);
        chk("t4_b_acc", acc0, 7);
        chk("t4_b_cnt", cnt[0], 1);
        step("t4", 0, 0, 16'sd0, 1, 0);

        // Clear collides with a beat
        step("t5", 1, 0, 16'sd40, 1, 0);
        step("t5", 1, 0, 16'sd50, 1, 1);
        chk("t5_clr_acc", acc0, 0);
        chk("t5_clr_cnt", cnt[0], 0);
        step("t5", 1, 0, 16'sd5, 1, 0);
        step("t5", 1, 1, 16'sd6, 0, 0);
        chk("t5_sum", acc0, 11);
        step("t5", 0, 0, 16'sd0, 1, 0);

        // Async reset mid-frame and in DONE
        step("t6", 1, 0, 16'sd123, 0, 0);
        async_reset("t6_mid");
        step("t6", 1, 1, 16'sd77, 0, 0);
        async_reset("t6_done");
        step("t6", 0, 0, 16'sd0, 1, 0);

        // Beat counter saturates at all-ones
        for (int i = 0; i < 258; i++) step("cnt", 1, 0, 16'sd1, 1, 0);
        step("cnt", 1, 1, 16'sd1, 0, 0);
        chk("cnt_sat", cnt[0], 255);
        step("cnt", 0, 0, 16'sd0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step("rnd", ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
                 16'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
